// File: rtl/dp_pkg.sv
// Shared definitions for the streaming dot-product engine: width helper,
// default fixed-point widths and the controller state encoding.
package dp_pkg;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    localparam int DP_PIX_W    = 10;
    localparam int DP_WGT_W    = 19;
    localparam int DP_WGT_FRAC = 16;
    localparam int DP_OUT_W    = 26;

    // Weight code for 1.0 in the signed WGT_FRAC fixed-point format.
    localparam logic [DP_WGT_W-1:0] WGT_ONE = DP_WGT_W'(1 << DP_WGT_FRAC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/dp_adder_tree.sv
// Registered binary adder tree. Each level halves the operand count and is
// followed by a register; a valid bit travels alongside the sums. With a
// single lane the tree collapses to a wire.
module dp_adder_tree
    import dp_pkg::*;
#(
    parameter int  LANES = 4,
    parameter int  IN_W  = 30,
    localparam int SUM_W = IN_W + clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [LANES*IN_W-1:0]   in_data,
    output logic                    out_valid,
    output logic signed [SUM_W-1:0] out_data
);

    localparam int LEVELS = clog2(LANES);
    localparam int NP     = 1 << LEVELS;

    logic signed [SUM_W-1:0] leaf [NP];

    // Sign-extend every lane to full tree width; pad up to a power of two with zeros.
    always_comb begin
        // NOTE: every element gets a default first so no path leaves it unassigned (no latch).
        for (int i = 0; i < NP; i++) begin
            leaf[i] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            leaf[i] = SUM_W'($signed(in_data[i*IN_W +: IN_W]));
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int N = NP >> k;

        logic signed [SUM_W-1:0] prev [2*N];
        logic                    prev_valid;
        logic signed [SUM_W-1:0] sum_d [N];
        logic signed [SUM_W-1:0] sum_q [N];
        logic                    valid_q;

        if (k == 1) begin : g_from_leaf
            assign prev       = leaf;
            assign prev_valid = in_valid;
        end else begin : g_from_lvl
            assign prev       = g_lvl[k-1].sum_q;
            assign prev_valid = g_lvl[k-1].valid_q;
        end

        // Pairwise sum of the level below.
        always_comb begin
            for (int i = 0; i < N; i++) begin
                sum_d[i] = prev[2*i] + prev[2*i+1];
            end
        end

        // Level register; bubbles flow through as zero sums with valid low.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                // NOTE: this is a handful of pipeline flops, not a RAM, so clearing it on reset is cheap and keeps a reset-aborted vector from leaking into the next one.
                for (int i = 0; i < N; i++) begin
                    sum_q[i] <= '0;
                end
            end else begin
                // NOTE: non-blocking so every level samples its neighbour's pre-edge value.
                valid_q <= prev_valid;
                sum_q   <= sum_d;
            end
        end
    end

    if (LEVELS == 0) begin : g_out_wire
        assign out_valid = in_valid;
        assign out_data  = leaf[0];
    end else begin : g_out_reg
        assign out_valid = g_lvl[LEVELS].valid_q;
        assign out_data  = g_lvl[LEVELS].sum_q[0];
    end

endmodule

// File: rtl/pipelined_dot_product_acc.sv
// Streaming fixed-point dot-product engine. Per beat, LANES unsigned pixels
// are multiplied by signed weights, reduced by a registered adder tree and
// accumulated at full precision until the in_last beat; the scaled and
// saturated result is then held until the consumer takes it.
module pipelined_dot_product_acc
    import dp_pkg::*;
#(
    parameter int  LANES     = 4,
    parameter int  PIX_W     = DP_PIX_W,
    parameter int  WGT_W     = DP_WGT_W,
    parameter int  WGT_FRAC  = DP_WGT_FRAC,
    parameter int  OUT_W     = DP_OUT_W,
    parameter int  OUT_SHIFT = 0,
    parameter int  MAX_BEATS = 256,
    localparam int BEAT_W    = clog2(MAX_BEATS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*PIX_W-1:0]  in_pixels,
    input  logic [LANES*WGT_W-1:0]  in_weights,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat,
    output logic [BEAT_W-1:0]       out_beats
);

    localparam int PROD_W    = PIX_W + WGT_W + 1;
    localparam int TREE_LVLS = clog2(LANES);
    localparam int SUM_W     = PROD_W + TREE_LVLS;
    localparam int ACC_W     = SUM_W + clog2(MAX_BEATS);
    // Product register + tree levels + accumulator, then the output register.
    localparam int LAT       = TREE_LVLS + 2;
    localparam int CNT_W     = clog2(LAT);

    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LAT - 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BEATS);

    logic                      accept;
    logic [LANES*PROD_W-1:0]   prod_d, prod_q;
    logic                      prod_valid_d, prod_valid_q;
    logic                      tree_valid;
    logic signed [SUM_W-1:0]   tree_sum;

    state_e                    state_d, state_q;
    logic [CNT_W-1:0]          cnt_d, cnt_q;
    logic signed [ACC_W-1:0]   acc_d, acc_q;
    logic [BEAT_W-1:0]         beats_d, beats_q;
    logic                      in_ready_d, in_ready_q;
    logic                      out_valid_d, out_valid_q;
    logic signed [OUT_W-1:0]   out_data_d, out_data_q;
    logic                      out_sat_d, out_sat_q;
    logic [BEAT_W-1:0]         out_beats_d, out_beats_q;

    logic signed [ACC_W-1:0]   shifted;
    logic signed [OUT_W-1:0]   sat_data;
    logic                      sat_flag;

    // Lane multipliers; a beat that is not accepted injects a zero bubble.
    always_comb begin
        accept       = in_valid && in_ready_q;
        prod_valid_d = accept;
        prod_d       = '0;
        for (int i = 0; i < LANES; i++) begin
            if (accept) begin
                prod_d[i*PROD_W +: PROD_W] =
                    PROD_W'($signed({1'b0, in_pixels[i*PIX_W +: PIX_W]}) *
                            $signed(in_weights[i*WGT_W +: WGT_W]));
            end
        end
    end

    // Product register feeding the adder tree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
        end else begin
            prod_q       <= prod_d;
            prod_valid_q <= prod_valid_d;
        end
    end

    dp_adder_tree #(
        .LANES (LANES),
        .IN_W  (PROD_W)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (prod_valid_q),
        .in_data   (prod_q),
        .out_valid (tree_valid),
        .out_data  (tree_sum)
    );

    // Floor-scale the accumulator and clip it into the signed OUT_W range.
    always_comb begin
        shifted = acc_q >>> OUT_SHIFT;
        if ((&shifted[ACC_W-1:OUT_W-1]) || !(|shifted[ACC_W-1:OUT_W-1])) begin
            sat_data = shifted[OUT_W-1:0];
            sat_flag = 1'b0;
        end else if (shifted[ACC_W-1]) begin
            sat_data = {1'b1, {(OUT_W-1){1'b0}}};
            sat_flag = 1'b1;
        end else begin
            sat_data = {1'b0, {(OUT_W-1){1'b1}}};
            sat_flag = 1'b1;
        end
    end

    // Controller next state: beat acceptance, drain countdown, result hand-off.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_beats_d = out_beats_q;

        if (tree_valid) begin
            acc_d = acc_q + ACC_W'(tree_sum);
        end
        if (accept && (beats_q != BEAT_MAX)) begin
            beats_d = beats_q + 1'b1;
        end

        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (in_last) begin
                        state_d = DRAIN;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            DRAIN: begin
                // The last beat's sum is in acc_q once the countdown expires.
                if (cnt_q == '0) begin
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
                    out_data_d  = sat_data;
                    out_sat_d   = sat_flag;
                    out_beats_d = beats_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    beats_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE) || (state_d == ACCUM);
    end

    // Controller, accumulator and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            beats_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_pipelined_dot_product_acc.sv
// Directed bench for the dot-product engine: a default build, a twin with
// OUT_SHIFT=16 sharing its stimulus, and a single-lane build.
module tb_pipelined_dot_product_acc;
    import dp_pkg::*;

    localparam int LANES  = 4;
    localparam int PIX_W  = DP_PIX_W;
    localparam int WGT_W  = DP_WGT_W;
    localparam int OUT_W  = DP_OUT_W;
    localparam int BEAT_W = clog2(256 + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic                     in_valid   = 1'b0;
    logic                     in_last    = 1'b0;
    logic                     out_ready  = 1'b0;
    logic [LANES*PIX_W-1:0]   in_pixels  = '0;
    logic [LANES*WGT_W-1:0]   in_weights = '0;
    logic                     in_ready, out_valid, out_sat;
    logic signed [OUT_W-1:0]  out_data;
    logic [BEAT_W-1:0]        out_beats;

    logic                     sh_in_ready, sh_out_valid, sh_out_sat;
    logic signed [OUT_W-1:0]  sh_out_data;
    logic [BEAT_W-1:0]        sh_out_beats;

    logic                     l1_in_valid  = 1'b0;
    logic                     l1_in_last   = 1'b0;
    logic                     l1_out_ready = 1'b0;
    logic [PIX_W-1:0]         l1_pixels    = '0;
    logic [WGT_W-1:0]         l1_weights   = '0;
    logic                     l1_in_ready, l1_out_valid, l1_out_sat;
    logic signed [OUT_W-1:0]  l1_out_data;
    logic [BEAT_W-1:0]        l1_out_beats;

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_dot_product_acc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixels(in_pixels), .in_weights(in_weights), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .out_beats(out_beats)
    );

    pipelined_dot_product_acc #(.OUT_SHIFT(16)) dut_sh (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sh_in_ready),
        .in_pixels(in_pixels), .in_weights(in_weights), .in_last(in_last),
        .out_valid(sh_out_valid), .out_ready(out_ready), .out_data(sh_out_data),
        .out_sat(sh_out_sat), .out_beats(sh_out_beats)
    );

    pipelined_dot_product_acc #(.LANES(1)) dut_l1 (
        .clk(clk), .rst(rst), .in_valid(l1_in_valid), .in_ready(l1_in_ready),
        .in_pixels(l1_pixels), .in_weights(l1_weights), .in_last(l1_in_last),
        .out_valid(l1_out_valid), .out_ready(l1_out_ready), .out_data(l1_out_data),
        .out_sat(l1_out_sat), .out_beats(l1_out_beats)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one beat with every lane equal; returns #1 after the accepting edge.
    task automatic send(input int pix, input logic [WGT_W-1:0] wgt, input bit last);
        int n = 0;
        in_valid = 1'b1;
        in_last  = last;
        for (int i = 0; i < LANES; i++) begin
            in_pixels[i*PIX_W +: PIX_W]  = PIX_W'(pix);
            in_weights[i*WGT_W +: WGT_W] = wgt;
        end
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_beat", in_ready, 1);
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Idle cycles with junk on the data/last lines, which must be ignored.
    task automatic gap(input int n);
        in_last    = 1'b1;
        in_pixels  = (LANES*PIX_W)'({$urandom(), $urandom()});
        in_weights = (LANES*WGT_W)'({$urandom(), $urandom(), $urandom()});
        repeat (n) begin
            @(posedge clk); #1;
        end
        check("gap_in_ready", in_ready, 1);
        in_last = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_seen", out_valid, 1);
        lat = cyc - acc_cyc;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("consume_valid_drop", out_valid, 0);
        check("consume_in_ready", in_ready, 1);
    endtask

    initial begin
        int lat;
        int vcount;
        int n;

        // Reset state
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_out_beats", out_beats, 0);
        check("rst_l1_out_valid", l1_out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single beat, weights 1.0
        send(50, WGT_ONE, 1'b1);
        wait_out(lat);
        check("single_latency", lat, 4);
        check("single_data", out_data, 13107200);
        check("single_sat", out_sat, 0);
        check("single_beats", out_beats, 1);
        check("single_sh_data", sh_out_data, 200);
        consume();

        // Three back-to-back beats, weights 0.25
        send(50, 19'h04000, 1'b0);
        send(100, 19'h04000, 1'b0);
        send(150, 19'h04000, 1'b1);
        wait_out(lat);
        check("three_latency", lat, 4);
        check("three_data", out_data, 19660800);
        check("three_sat", out_sat, 0);
        check("three_beats", out_beats, 3);
        check("three_sh_data", sh_out_data, 300);
        consume();

        // Same vector with idle gaps between beats
        send(50, 19'h04000, 1'b0);
        gap(1);
        send(100, 19'h04000, 1'b0);
        gap(3);
        send(150, 19'h04000, 1'b1);
        wait_out(lat);
        check("gapped_data", out_data, 19660800);
        check("gapped_beats", out_beats, 3);

        // Backpressure: result held for ten cycles
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 19660800);
            check("bp_in_ready", in_ready, 0);
        end
        consume();

        // Eight beats of 1023 * -1.0: clipped at OUT_SHIFT=0, fits at 16
        for (int b = 0; b < 8; b++) begin
            send(1023, 19'h70000, (b == 7));
        end
        wait_out(lat);
        check("neg_data", out_data, -33554432);
        check("neg_sat", out_sat, 1);
        check("neg_beats", out_beats, 8);
        check("neg_sh_data", sh_out_data, -32736);
        check("neg_sh_sat", sh_out_sat, 0);
        check("neg_sh_beats", sh_out_beats, 8);
        consume();

        // Reset asserted while draining
        send(50, WGT_ONE, 1'b1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("drain_rst_out_valid", out_valid, 0);
        check("drain_rst_out_data", out_data, 0);
        check("drain_rst_out_sat", out_sat, 0);
        check("drain_rst_in_ready", in_ready, 0);
        check("drain_rst_sh_in_ready", sh_in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) vcount++;
        end
        check("drain_rst_no_partial", vcount, 0);
        send(50, WGT_ONE, 1'b1);
        wait_out(lat);
        check("post_rst_latency", lat, 4);
        check("post_rst_data", out_data, 13107200);
        check("post_rst_sat", out_sat, 0);
        check("post_rst_beats", out_beats, 1);
        consume();

        // Single-lane build: 3 * -2^-16
        l1_pixels   = 10'd3;
        l1_weights  = 19'h7FFFF;
        l1_in_last  = 1'b1;
        l1_in_valid = 1'b1;
        n = 0;
        while (!l1_in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("l1_in_ready", l1_in_ready, 1);
        @(posedge clk); #1;
        acc_cyc     = cyc;
        l1_in_valid = 1'b0;
        l1_in_last  = 1'b0;
        n = 0;
        while (!l1_out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("l1_out_valid", l1_out_valid, 1);
        check("l1_latency", cyc - acc_cyc, 2);
        check("l1_data", l1_out_data, -3);
        check("l1_sat", l1_out_sat, 0);
        check("l1_beats", l1_out_beats, 1);
        l1_out_ready = 1'b1;
        @(posedge clk); #1;
        l1_out_ready = 1'b0;
        check("l1_valid_drop", l1_out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
